// File: rtl/hilo_commit_pipe.sv
// hilo_commit_pipe: carries HI/LO write requests from EX through the EX/MEM
// and MEM/WB pipeline registers, then commits them to architectural HI/LO.
// The MEM copy, WB copy and architectural values are all registered outputs
// that EX uses as forwarding sources (priority mem > wb > arch is applied in EX).
//
// Transfer semantics: there is no valid/ready handshake. Each *_whilo flag is a
// valid bit that qualifies its stage's data, and there is no backpressure except
// through the stall vector. stall[k] freezes stage k. A stage whose upstream is
// stalled while it is free to drain loads a bubble: whilo=0 with data zeroed.
// A stage whose upstream is free captures unconditionally, including the data of
// whilo=0 requests.
module hilo_commit_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [DATA_W-1:0] ex_hi_i,
  input  logic [DATA_W-1:0] ex_lo_i,
  input  logic              ex_whilo_i,
  output logic [DATA_W-1:0] mem_hi_o,
  output logic [DATA_W-1:0] mem_lo_o,
  output logic              mem_whilo_o,
  output logic [DATA_W-1:0] wb_hi_o,
  output logic [DATA_W-1:0] wb_lo_o,
  output logic              wb_whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] mem_hi_q, mem_hi_d;
  logic [DATA_W-1:0] mem_lo_q, mem_lo_d;
  logic              mem_whilo_q, mem_whilo_d;
  logic [DATA_W-1:0] wb_hi_q, wb_hi_d;
  logic [DATA_W-1:0] wb_lo_q, wb_lo_d;
  logic              wb_whilo_q, wb_whilo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // EX/MEM register: capture when EX advances, bubble when EX is stalled but MEM drains, otherwise hold.
  always_comb begin
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    mem_whilo_d = mem_whilo_q;
    if (!stall[3]) begin
      mem_hi_d    = ex_hi_i;
      mem_lo_d    = ex_lo_i;
      mem_whilo_d = ex_whilo_i;
    end else if (!stall[4]) begin
      mem_hi_d    = '0;
      mem_lo_d    = '0;
      mem_whilo_d = 1'b0;
    end
  end

  // MEM/WB register: same rule one stage later, sourced from the MEM copy.
  always_comb begin
    wb_hi_d    = wb_hi_q;
    wb_lo_d    = wb_lo_q;
    wb_whilo_d = wb_whilo_q;
    if (!stall[4]) begin
      wb_hi_d    = mem_hi_q;
      wb_lo_d    = mem_lo_q;
      wb_whilo_d = mem_whilo_q;
    end else if (!stall[5]) begin
      wb_hi_d    = '0;
      wb_lo_d    = '0;
      wb_whilo_d = 1'b0;
    end
  end

  // Architectural commit: both halves written whenever WB holds a valid request.
  // Independent of stall[5]; recommitting a held WB entry writes the same values.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo_q) begin
      hi_d = wb_hi_q;
      lo_d = wb_lo_q;
    end
  end

  // State registers; reset clears everything and overrides any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      mem_whilo_q <= 1'b0;
      wb_hi_q     <= '0;
      wb_lo_q     <= '0;
      wb_whilo_q  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      mem_whilo_q <= mem_whilo_d;
      wb_hi_q     <= wb_hi_d;
      wb_lo_q     <= wb_lo_d;
      wb_whilo_q  <= wb_whilo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign mem_hi_o    = mem_hi_q;
  assign mem_lo_o    = mem_lo_q;
  assign mem_whilo_o = mem_whilo_q;
  assign wb_hi_o     = wb_hi_q;
  assign wb_lo_o     = wb_lo_q;
  assign wb_whilo_o  = wb_whilo_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule
